// File: rtl/mem_wb_regfile.sv
// EX/MEM and MEM/WB pipeline registers feeding a GPR file with two forwarding read ports.
// Register 0 is hardwired to zero; in-flight results are forwarded newest-first.
module mem_wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] io_inFromE_rWAddr,
  input  logic              io_inFromE_rWEn,
  input  logic [DATA_W-1:0] io_inFromE_rWData,
  input  logic              io_stall,
  input  logic              io_flush,
  input  logic [ADDR_W-1:0] io_rAddr1,
  input  logic              io_rEn1,
  input  logic [ADDR_W-1:0] io_rAddr2,
  input  logic              io_rEn2,
  output logic [DATA_W-1:0] io_rData1,
  output logic [DATA_W-1:0] io_rData2,
  output logic [ADDR_W-1:0] io_wbOut_rWAddr,
  output logic              io_wbOut_rWEn,
  output logic [DATA_W-1:0] io_wbOut_rWData
);

  localparam int NREG = 1 << ADDR_W;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } stage_t;

  stage_t            w_in;
  stage_t            r_m;
  stage_t            r_w;
  logic [DATA_W-1:0] r_gpr [NREG];
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  assign w_in = {io_inFromE_rWEn, io_inFromE_rWAddr, io_inFromE_rWData};

  // Flush takes precedence over stall on the MEM stage; WB only honours stall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_m <= '0;
      r_w <= '0;
    end else begin
      if (io_flush) begin
        r_m <= '0;
      end else if (!io_stall) begin
        r_m <= w_in;
      end
      if (!io_stall) begin
        r_w <= r_m;
      end
    end
  end

  // NOTE: the GPR file must clear on reset, so it is a flop array rather than an inferred RAM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_gpr[i] <= '0;
      end
    end else if (r_w.en && (r_w.addr != '0)) begin
      r_gpr[r_w.addr] <= r_w.data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic              en,
    input logic [DATA_W-1:0] gpr_val,
    input stage_t            s_in,
    input stage_t            s_m,
    input stage_t            s_w
  );
    logic [DATA_W-1:0] val;
    val = gpr_val;
    if (!en || (addr == '0)) begin
      val = '0;
    end else if (BYPASS != 0) begin
      if (s_in.en && (s_in.addr == addr)) begin
        val = s_in.data;
      end else if (s_m.en && (s_m.addr == addr)) begin
        val = s_m.data;
      end else if (s_w.en && (s_w.addr == addr)) begin
        val = s_w.data;
      end
    end
    return val;
  endfunction

  always_comb begin
    w_rd1 = read_port(io_rAddr1, io_rEn1, r_gpr[io_rAddr1], w_in, r_m, r_w);
    w_rd2 = read_port(io_rAddr2, io_rEn2, r_gpr[io_rAddr2], w_in, r_m, r_w);
  end

  // Reset also masks the live EX triple, which would otherwise forward straight through.
  assign io_rData1 = reset ? w_rd1 : '0;
  assign io_rData2 = reset ? w_rd2 : '0;

  assign io_wbOut_rWAddr = r_w.addr;
  assign io_wbOut_rWEn   = r_w.en;
  assign io_wbOut_rWData = r_w.data;

endmodule
